// File: rtl/game_pkg.sv
// Shared game definitions: state encodings and the 4-digit BCD score type used
// by the score keeper and the pipe/block controllers.
package game_pkg;

    localparam int BCD_W      = 4;
    localparam int BCD_DIGITS = 4;

    typedef logic [BCD_DIGITS*BCD_W-1:0] bcd16_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAYING = 2'b01,
        ST_OVER    = 2'b10
    } game_state_t;

    // Valid packed BCD orders the same as plain binary, so an unsigned
    // compare is an MSD-first digit compare.
    function automatic logic bcd_gt(input bcd16_t a, input bcd16_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/bcd_inc4.sv
// Combinational 4-digit BCD incrementer; holds its input at the all-max value
// and flags that with carry_out.
module bcd_inc4
    import game_pkg::*;
#(
    parameter int MAX_DIGIT = 9
) (
    input  bcd16_t value,
    output bcd16_t result,
    output logic   carry_out
);

    logic [BCD_DIGITS:0] carry;
    bcd16_t              rolled;

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            logic [BCD_W-1:0] digit;
            logic             at_max;

            assign digit  = value[gi*BCD_W +: BCD_W];
            assign at_max = (digit == BCD_W'(MAX_DIGIT));
            assign carry[gi+1] = carry[gi] & at_max;
            assign rolled[gi*BCD_W +: BCD_W] =
                !carry[gi] ? digit : (at_max ? '0 : digit + 1'b1);
        end
    endgenerate

    // A carry out of the top digit means every digit was at max: saturate.
    assign carry_out = carry[BCD_DIGITS];
    assign result    = carry_out ? value : rolled;

endmodule

// File: rtl/score_keeper.sv
// Flappy Bird game-state machine and BCD score/best-score keeper, with the
// seven-segment digit select and leading-zero / new-best flash blanking.
module score_keeper
    import game_pkg::*;
#(
    parameter int MAX_DIGIT  = 9,
    parameter int FLASH_BITS = 5,
    parameter int OVER_HOLD  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pipe_pass,
    input  logic        collision,
    input  logic        show_best,
    output logic [1:0]  game_state,
    output logic [15:0] score,
    output logic [15:0] best,
    output logic [15:0] ssd_digits,
    output logic [3:0]  ssd_blank,
    output logic        new_best
);

    localparam int HOLD_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD - 1);

    game_state_t           state_reg, state_next;
    bcd16_t                score_reg, score_next;
    bcd16_t                best_reg, best_next;
    logic                  new_best_reg, new_best_next;
    logic [HOLD_W-1:0]     hold_reg, hold_next;
    logic [FLASH_BITS-1:0] flash_reg, flash_next;

    logic start_prev_reg, pass_prev_reg, coll_prev_reg;
    logic start_rise, pass_rise, coll_rise;

    bcd16_t score_inc, score_upd;
    logic   score_carry;

    assign start_rise = start & ~start_prev_reg;
    assign pass_rise  = pipe_pass & ~pass_prev_reg;
    assign coll_rise  = collision & ~coll_prev_reg;

    bcd_inc4 #(
        .MAX_DIGIT(MAX_DIGIT)
    ) u_score_inc (
        .value    (score_reg),
        .result   (score_inc),
        .carry_out(score_carry)
    );

    // Score as it stands after this cycle's pass event, so a simultaneous
    // collision compares against the incremented value.
    assign score_upd = (pass_rise && !score_carry) ? score_inc : score_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            score_reg      <= '0;
            best_reg       <= '0;
            new_best_reg   <= 1'b0;
            hold_reg       <= '0;
            flash_reg      <= '0;
            start_prev_reg <= 1'b0;
            pass_prev_reg  <= 1'b0;
            coll_prev_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            score_reg      <= score_next;
            best_reg       <= best_next;
            new_best_reg   <= new_best_next;
            hold_reg       <= hold_next;
            flash_reg      <= flash_next;
            start_prev_reg <= start;
            pass_prev_reg  <= pipe_pass;
            coll_prev_reg  <= collision;
        end
    end

    always_comb begin
        state_next    = state_reg;
        score_next    = score_reg;
        best_next     = best_reg;
        new_best_next = new_best_reg;
        hold_next     = hold_reg;
        flash_next    = flash_reg + 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (start_rise) begin
                    state_next    = ST_PLAYING;
                    score_next    = '0;
                    new_best_next = 1'b0;
                end
            end
            ST_PLAYING: begin
                score_next = score_upd;
                if (coll_rise) begin
                    state_next = ST_OVER;
                    hold_next  = '0;
                    flash_next = '0;
                    if (bcd_gt(score_upd, best_reg)) begin
                        best_next     = score_upd;
                        new_best_next = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (hold_reg != HOLD_MAX) begin
                    hold_next = hold_reg + 1'b1;
                end
                if (start_rise && hold_reg == HOLD_MAX) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    logic [3:0] lead_blank;
    logic       flash_on;

    assign ssd_digits    = show_best ? best_reg : score_reg;
    assign lead_blank[3] = (ssd_digits[15:12] == '0);
    assign lead_blank[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < BCD_DIGITS - 1; gi++) begin : g_blank
            assign lead_blank[gi] = lead_blank[gi+1] &
                                    (ssd_digits[gi*BCD_W +: BCD_W] == '0);
        end
    endgenerate

    assign flash_on   = (state_reg == ST_OVER) && new_best_reg && flash_reg[FLASH_BITS-1];
    assign ssd_blank  = flash_on ? 4'b1111 : lead_blank;
    assign game_state = state_reg;
    assign score      = score_reg;
    assign best       = best_reg;
    assign new_best   = new_best_reg && (state_reg == ST_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Directed plus randomized bench for score_keeper, checked every cycle against
// a decimal-arithmetic model of the game rules.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pipe_pass, collision, show_best;
    logic [1:0]  game_state;
    logic [15:0] score, best, ssd_digits;
    logic [3:0]  ssd_blank;
    logic        new_best;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: plain integers, 0 idle / 1 playing / 2 over.
    int m_state, m_score, m_best, over_entry;
    bit m_nb;

    score_keeper #(
        .MAX_DIGIT (9),
        .FLASH_BITS(5),
        .OVER_HOLD (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pipe_pass (pipe_pass),
        .collision (collision),
        .show_best (show_best),
        .game_state(game_state),
        .score     (score),
        .best      (best),
        .ssd_digits(ssd_digits),
        .ssd_blank (ssd_blank),
        .new_best  (new_best)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] mask_of(input int v);
        if (v >= 1000) return 4'b0000;
        if (v >= 100)  return 4'b1000;
        if (v >= 10)   return 4'b1100;
        return 4'b1110;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int         shown;
        logic [3:0] eb;
        shown = show_best ? m_best : m_score;
        if (m_state == 2 && m_nb && ((cyc - over_entry) / 16) % 2 == 1) eb = 4'b1111;
        else eb = mask_of(shown);
        chk({tag, ":state"}, 16'(game_state), 16'(m_state));
        chk({tag, ":score"}, score, to_bcd(m_score));
        chk({tag, ":best"}, best, to_bcd(m_best));
        chk({tag, ":digits"}, ssd_digits, to_bcd(shown));
        chk({tag, ":blank"}, 16'(ssd_blank), 16'(eb));
        chk({tag, ":new_best"}, 16'(new_best), 16'(m_nb && m_state == 2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_best = 0; m_nb = 0; over_entry = 0;
    endtask

    task automatic model_apply(input bit s, input bit p, input bit c);
        case (m_state)
            0: if (s) begin m_state = 1; m_score = 0; m_nb = 0; end
            1: begin
                if (p && m_score < 9999) m_score++;
                if (c) begin
                    m_state = 2;
                    over_entry = cyc;
                    if (m_score > m_best) begin m_best = m_score; m_nb = 1; end
                end
            end
            default: if (s && cyc - over_entry >= 64) m_state = 0;
        endcase
    endtask

    // Raise the requested inputs for one edge, then drop them for one edge.
    task automatic ev(input bit s, input bit p, input bit c, input string tag);
        start = s; pipe_pass = p; collision = c;
        tick();
        model_apply(s, p, c);
        check_all(tag);
        start = 0; pipe_pass = 0; collision = 0;
        tick();
        check_all({tag, "_rel"});
    endtask

    task automatic wait_cycles(input int n, input string tag);
        repeat (n) begin
            tick();
            check_all(tag);
        end
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #2;
        rst_n = 1'b1;
        tick();
        check_all({tag, "_post"});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; pipe_pass = 0; collision = 0; show_best = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        #2;
        rst_n = 1'b1;
        tick();

        // Events in IDLE are ignored.
        ev(0, 1, 0, "idle_pass");
        ev(0, 0, 1, "idle_coll");
        ev(1, 0, 0, "start1");

        for (int i = 0; i < 12; i++) begin
            ev(0, 1, 0, "pass12");
            wait_cycles($urandom_range(0, 2), "gap");
        end
        chk("score_0012", score, 16'h0012);
        chk("blank_1100", 16'(ssd_blank), 16'h000C);

        repeat (987) ev(0, 1, 0, "to999");
        chk("score_0999", score, 16'h0999);
        ev(0, 1, 0, "roll1000");
        chk("score_1000", score, 16'h1000);
        chk("blank_0000", 16'(ssd_blank), 16'h0000);
        repeat (8999) ev(0, 1, 0, "to9999");
        ev(0, 1, 0, "sat");
        chk("score_sat", score, 16'h9999);
        ev(1, 0, 0, "start_in_play");
        chk("start_ignored", 16'(game_state), 16'h0001);

        async_reset("rst_a");

        // Game with simultaneous pass and collision at score 5.
        ev(1, 0, 0, "start2");
        repeat (5) begin
            ev(0, 1, 0, "pass5");
            wait_cycles($urandom_range(0, 2), "gap");
        end
        ev(0, 1, 1, "pass_coll");
        chk("both_score", score, 16'h0006);
        chk("both_best", best, 16'h0006);
        chk("both_state", 16'(game_state), 16'h0002);
        chk("both_nb", 16'(new_best), 16'h0001);
        wait_cycles(8, "over_wait");
        ev(1, 0, 0, "early_start");
        chk("early_start_state", 16'(game_state), 16'h0002);
        wait_cycles(60, "flash");
        ev(1, 0, 0, "late_start");
        chk("late_start_state", 16'(game_state), 16'h0000);
        chk("score_kept", score, 16'h0006);

        // Worse second game: best kept, no new-best flag.
        ev(1, 0, 0, "start3");
        repeat (3) ev(0, 1, 0, "pass3");
        ev(0, 0, 1, "coll3");
        chk("best_kept", best, 16'h0006);
        chk("nb_clear", 16'(new_best), 16'h0000);
        show_best = 1'b1;
        #1;
        chk("show_best_digits", ssd_digits, 16'h0006);
        wait_cycles(70, "over3");
        show_best = 1'b0;
        ev(1, 0, 0, "to_idle3");
        ev(1, 0, 0, "start4");
        for (int i = 0; i < 42; i++) begin
            ev(0, 1, 0, "pass42");
            wait_cycles($urandom_range(0, 1), "gap");
        end
        chk("score_0042", score, 16'h0042);
        async_reset("rst_mid");

        // Randomized games against the model.
        for (int g = 0; g < 4; g++) begin
            int n;
            ev(1, 0, 0, "rg_start");
            n = $urandom_range(0, 25);
            for (int i = 0; i < n; i++) begin
                ev(0, 1, 0, "rg_pass");
                wait_cycles($urandom_range(0, 2), "rg_gap");
            end
            ev(0, 1'($urandom_range(0, 1)), 1, "rg_coll");
            show_best = 1'($urandom_range(0, 1));
            wait_cycles($urandom_range(64, 80), "rg_over");
            ev(1, 0, 0, "rg_idle");
            show_best = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-state and score engine for the Flappy Bird datapath.
- Consumes pipe-pass and collision events from the pipe and block controllers, runs the IDLE/PLAYING/OVER state machine, and keeps the current score and best score as 4-digit BCD.
- Produces four BCD nibbles and a per-digit blank mask that feed the seven-segment scan/decode stage directly; the 16-bit score bus in vga_top is driven from here.

Parameters:
- MAX_DIGIT, 9, highest BCD value per digit.
- FLASH_BITS, 5, width of blink counter; display toggles every 2^(FLASH_BITS-1) clk cycles in OVER.
- OVER_HOLD, 64, minimum clk cycles spent in OVER before start is accepted.

Ports:
- clk  in  1  movement clock shared with pipe/block controllers (DIV_CLK[19] domain).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level from BtnU; rising edge detected internally.
- pipe_pass  in  1  level, high while bird x lies past the trailing edge of the current pipe.
- collision  in  1  level, high while bird overlaps a pipe or a screen edge.
- show_best  in  1  level; selects best score on the digit outputs.
- game_state  out  2  00 IDLE, 01 PLAYING, 10 OVER.
- score  out  16  current score, BCD {d3,d2,d1,d0}.
- best  out  16  best score, BCD.
- ssd_digits  out  16  BCD digits to the SSD mux (score or best).
- ssd_blank  out  4  1 = digit dark; leading zeros blanked, digit0 never blanked.
- new_best  out  1  high in OVER when the last game set a new best.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - game_state=IDLE; score=best=0000; new_best=0.
  - ssd_blank=4'b1110; edge registers cleared; hold and flash counters cleared.
- Edge detect: start, pipe_pass and collision each registered once; rise = cur & ~prev.
  - Each rise is a 1-cycle pulse acted on in the next cycle, giving 1-cycle event-to-output latency.
- IDLE:
  - start rise -> PLAYING; score cleared to 0000 in the same transition; new_best cleared.
- PLAYING:
  - pipe_pass rise increments score by 1 in BCD: digit rolls 9->0 and carries into the next digit.
  - At 9999, score saturates; no wrap.
  - collision rise -> OVER. The compare runs against the score as updated this cycle: if collision rise and pipe_pass rise arrive together, the increment is applied first.
  - If score > best (BCD unsigned compare, MSD first): best <= score and new_best <= 1.
  - start is ignored while in PLAYING.
- OVER:
  - Hold counter counts to OVER_HOLD-1 and then saturates.
  - start rise is accepted only once the counter is saturated -> IDLE. Score is kept until the next start in IDLE.
  - Flash counter free-runs; while its MSB is 1 and new_best is 1, ssd_blank=4'b1111.
- Display:
  - ssd_digits = show_best ? best : score, combinational from registers.
  - Blank rule: d3 is blank if 0; d2 is blank if d3 and d2 are 0; d1 likewise; d0 is never blank.
- Events outside PLAYING (pipe_pass, collision) are ignored.
- Illegal state 11 -> IDLE next cycle.
- Reset asserted mid-game clears best as well; there is no persistence.

Decomposition:
- Shared package game_pkg holds:
  - state encodings ST_IDLE/ST_PLAYING/ST_OVER;
  - BCD width constant BCD_W=4;
  - the 16-bit BCD type used by pipe and block controllers.
- One sub-module: bcd_inc4, a 4-digit BCD incrementer with saturate-at-9999 and carry-out. It is combinational and instantiated once for score.

Test Plan:
- Reset release, then start pulse, then 12 pipe_pass pulses -> game_state=01, score=0x0012, ssd_blank=4'b1100.
- Score preloaded to 0x0999 by 999 passes, then one more pass -> score=0x1000, ssd_blank=0000; with passes continuing to 0x9999, one more pass -> stays 0x9999.
- Score 0x0005, collision and pipe_pass rising in the same cycle -> score=0x0006, OVER, best=0x0006, new_best=1.
- Second game: start pressed 10 cycles into OVER is ignored; pressed after 64 cycles -> IDLE; then play to score 0x0003 and collide -> best stays 0x0006, new_best=0, show_best=1 gives ssd_digits=0x0006.
- In OVER with new_best=1 -> ssd_blank alternates 1111 / prior mask every 16 cycles.
- rst_n pulsed low mid-PLAYING at score 0x0042 -> all outputs return to reset values immediately, without waiting for clk.
